// File: rtl/snn_syn_pkg.sv
// snn_syn_pkg: shared constants, FSM states and tag/entry types for the synapse fetch path
package snn_syn_pkg;

    localparam int N_PRE      = 100;
    localparam int N_POST     = 100;
    localparam int IDX_WIDTH  = 7;
    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 8;
    localparam int RD_LATENCY = 2;
    localparam int OBUF_DEPTH = 4;
    localparam int CNT_WIDTH  = $clog2(OBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] post_idx;
        logic                 last;
    } tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [DATA_WIDTH-1:0] weight;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

// File: rtl/syn_out_fifo.sv
// syn_out_fifo: small synchronous output buffer with occupancy count; push and pop may share a cycle
module syn_out_fifo
    import snn_syn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [ENTRY_WIDTH-1:0] i_data,
    input  logic                   i_pop,
    output logic [ENTRY_WIDTH-1:0] o_data,
    output logic                   o_valid,
    output logic [CNT_WIDTH-1:0]   o_count
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

    logic [ENTRY_WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [PW-1:0]          r_wr;
    logic [PW-1:0]          r_rd;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   w_pop;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_valid = r_cnt != '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];

    // pointers wrap explicitly so non-power-of-two depths also work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wr <= (r_wr == PW'(OBUF_DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)
                r_rd <= (r_rd == PW'(OBUF_DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_cnt <= r_cnt + CNT_WIDTH'(i_push) - CNT_WIDTH'(w_pop);
        end
    end

    // storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/synapse_fetch_ctrl.sv
// synapse_fetch_ctrl: walks a presynaptic neuron's weight row in synapse_mem and streams
// {post_idx, weight, last} downstream through a credit-checked buffer.
// Optional build macro ZERO_SKIP_EN drops zero-weight entries except the row's last one.
module synapse_fetch_ctrl
    import snn_syn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_spk_valid,
    input  logic [IDX_WIDTH-1:0]  i_spk_idx,
    output logic                  o_spk_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_syn_valid,
    input  logic                  i_syn_ready,
    output logic [IDX_WIDTH-1:0]  o_syn_post_idx,
    output logic [DATA_WIDTH-1:0] o_syn_weight,
    output logic                  o_syn_last,
    output logic                  o_busy,
    output logic                  o_err
);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_WIDTH-1:0]  r_row_base;
    logic [ADDR_WIDTH-1:0]  r_rd_addr;
    logic [IDX_WIDTH-1:0]   r_post_cnt;
    logic [RD_LATENCY:0]    r_tv;
    tag_t                   r_tag [RD_LATENCY+1];
    logic                   r_rdy;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_last;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_cap;
    logic                   w_push;
    logic [ENTRY_WIDTH-1:0] w_fdata;
    logic                   w_fvalid;
    logic [CNT_WIDTH-1:0]   w_occ;
    entry_t                 w_head;

    assign w_accept = i_spk_valid && r_rdy;
    assign w_legal  = i_spk_idx < IDX_WIDTH'(N_PRE);
    assign w_last   = r_post_cnt == IDX_WIDTH'(N_POST - 1);
    assign w_credit = (int'(w_occ) + $countones(r_tv)) < OBUF_DEPTH;
    assign w_cap    = r_tv[RD_LATENCY];

`ifdef ZERO_SKIP_EN
    assign w_push = w_cap && (r_tag[RD_LATENCY].last || i_rd_data != '0);
`else
    assign w_push = w_cap;
`endif

    // next state and issue decision
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        if (r_state == IDLE) begin
            w_next = (w_accept && w_legal) ? ISSUE : IDLE;
        end else if (r_state == ISSUE) begin
            w_issue = w_credit;
            w_next  = (w_credit && w_last) ? DRAIN : ISSUE;
        end else begin
            w_next = (r_tv == '0) ? IDLE : DRAIN;
        end
    end

    // state register; ready is registered so it reads 0 in the cycle right after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= w_next == IDLE;
            r_err   <= w_accept && !w_legal;
        end
    end

    // row base latch on accept, address counter advance on issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_base <= '0;
            r_post_cnt <= '0;
            r_rd_addr  <= '0;
        end else if (w_accept && w_legal) begin
            r_row_base <= ADDR_WIDTH'(i_spk_idx) * ADDR_WIDTH'(N_POST);
            r_post_cnt <= '0;
        end else if (w_issue) begin
            r_rd_addr  <= r_row_base + ADDR_WIDTH'(r_post_cnt);
            r_post_cnt <= r_post_cnt + 1'b1;
        end
    end

    // tag valid pipe: stage 0 sits beside o_rd_addr, last stage lines up with returning data
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_tv <= '0;
        else
            r_tv <= {r_tv[RD_LATENCY-1:0], w_issue};
    end

    // tag payload follows the valid pipe; stale payload is harmless behind a cleared valid
    always_ff @(posedge clk) begin
        r_tag[0] <= '{post_idx: r_post_cnt, last: w_last};
        for (int k = 1; k <= RD_LATENCY; k++)
            r_tag[k] <= r_tag[k-1];
    end

    syn_out_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_tag[RD_LATENCY], i_rd_data}),
        .i_pop   (i_syn_ready),
        .o_data  (w_fdata),
        .o_valid (w_fvalid),
        .o_count (w_occ)
    );

    assign w_head         = entry_t'(w_fdata);
    assign o_spk_ready    = r_rdy;
    assign o_rd_addr      = r_rd_addr;
    assign o_err          = r_err;
    assign o_syn_valid    = w_fvalid;
    assign o_syn_post_idx = w_fvalid ? w_head.tag.post_idx : '0;
    assign o_syn_weight   = w_fvalid ? w_head.weight : '0;
    assign o_syn_last     = w_fvalid && w_head.tag.last;
    assign o_busy         = (r_state != IDLE) || w_fvalid;

endmodule

// File: tb/tb_synapse_fetch_ctrl.sv
// tb_synapse_fetch_ctrl: randomized scenarios against a row-level reference model and a
// two-cycle BRAM model holding weight[a] = a[7:0] (optionally zeroed at chosen addresses).
module tb_synapse_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_spk_valid = 1'b0;
    logic [6:0]  i_spk_idx = '0;
    logic [7:0]  i_rd_data = '0;
    logic        i_syn_ready = 1'b0;
    logic        o_spk_ready;
    logic [13:0] o_rd_addr;
    logic        o_syn_valid;
    logic [6:0]  o_syn_post_idx;
    logic [7:0]  o_syn_weight;
    logic        o_syn_last;
    logic        o_busy;
    logic        o_err;

    int n_chk = 0;
    int n_pass = 0;
    int mode = 0;
    int cyc_g = 0;
    int outstanding = 0;
    int max_out = 0;
    logic zero_mode = 1'b0;
    int zrow = 0;
    logic [13:0] prev_addr = '0;
    logic [7:0] m1 = '0;
    logic [13:0] addr_q[$];
    logic [15:0] out_q[$];
    logic [15:0] exp_q[$];

    synapse_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_spk_valid    (i_spk_valid),
        .i_spk_idx      (i_spk_idx),
        .o_spk_ready    (o_spk_ready),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (i_rd_data),
        .o_syn_valid    (o_syn_valid),
        .i_syn_ready    (i_syn_ready),
        .o_syn_post_idx (o_syn_post_idx),
        .o_syn_weight   (o_syn_weight),
        .o_syn_last     (o_syn_last),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wt(int a);
        if (zero_mode && (a == zrow*100 || a == zrow*100 + 10 || a == zrow*100 + 99))
            return 8'd0;
        return 8'(a);
    endfunction

    // BRAM: address seen in cycle c yields data during cycle c+2
    always @(posedge clk) begin
        m1 <= wt(int'(o_rd_addr));
        i_rd_data <= m1;
    end

    // observe issued addresses, popped entries and outstanding work
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rd_addr !== prev_addr) begin
                addr_q.push_back(o_rd_addr);
                outstanding++;
            end
            if (o_syn_valid && i_syn_ready) begin
                out_q.push_back({o_syn_post_idx, o_syn_weight, o_syn_last});
                outstanding--;
            end
            if (outstanding > max_out)
                max_out = outstanding;
        end
        prev_addr = o_rd_addr;
    end

    // expected stream for n consecutive rows starting at r0
    function automatic void build(int r0, int n);
        logic [7:0] w;
        exp_q.delete();
        for (int r = r0; r < r0 + n; r++)
            for (int p = 0; p < 100; p++) begin
                w = wt(r*100 + p);
`ifdef ZERO_SKIP_EN
                if (w == 8'd0 && p != 99)
                    continue;
`endif
                exp_q.push_back({7'(p), w, p == 99});
            end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_g++;
        i_syn_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc_g % 3 == 0) : 1'($urandom_range(0, 1));
    endtask

    task automatic send_spike(int idx);
        int n = 0;
        while (!o_spk_ready && n < 1000) begin
            tick();
            n++;
        end
        n_chk++;
        if (!o_spk_ready)
            $display("FAIL spike_ready_timeout idx=%0d got ready=%0b want 1", idx, o_spk_ready);
        else
            n_pass++;
        i_spk_valid = 1'b1;
        i_spk_idx = 7'(idx);
        tick();
        i_spk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_busy || !o_spk_ready) && n < 3000) begin
            tick();
            n++;
        end
        n_chk++;
        if (o_busy)
            $display("FAIL idle_timeout got busy=%0b want 0", o_busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_chk++; if (o_spk_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", o_spk_ready); else n_pass++;
        n_chk++; if (o_rd_addr !== 14'd0) $display("FAIL rst_addr got %0d want 0", o_rd_addr); else n_pass++;
        n_chk++; if (o_syn_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", o_syn_valid); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", o_busy); else n_pass++;
        n_chk++; if (o_err !== 1'b0) $display("FAIL rst_err got %0b want 0", o_err); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_chk++; if (o_spk_ready !== 1'b1) $display("FAIL rst_ready_after got %0b want 1", o_spk_ready); else n_pass++;
        addr_q.delete();
        out_q.delete();
        outstanding = 0;
    endtask

    task automatic test_row(string name, int r, int m);
        mode = m;
        max_out = 0;
        send_spike(r);
        wait_idle();
        build(r, 1);
        n_chk++;
        if (addr_q.size() != 100) $display("FAIL %s_addr_count got %0d want 100", name, addr_q.size()); else n_pass++;
        for (int k = 0; k < addr_q.size() && k < 100; k++) begin
            n_chk++;
            if (addr_q[k] !== 14'(r*100 + k)) $display("FAIL %s_addr[%0d] got %0d want %0d", name, k, addr_q[k], r*100 + k);
            else n_pass++;
        end
        n_chk++;
        if (out_q.size() != exp_q.size()) $display("FAIL %s_entry_count got %0d want %0d", name, out_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            n_chk++;
            if (out_q[k] !== exp_q[k]) $display("FAIL %s_entry[%0d] got %h want %h", name, k, out_q[k], exp_q[k]);
            else n_pass++;
        end
        addr_q.delete();
        out_q.delete();
    endtask

    task automatic test_stream();
        test_row("t1_row3", 3, 0);
    endtask

    task automatic test_backpressure();
        test_row("t2_row4", 4, 1);
        n_chk++;
        if (max_out > 4) $display("FAIL t2_outstanding got %0d want <=4", max_out); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [13:0] a0;
        mode = 0;
        a0 = o_rd_addr;
        send_spike(100);
        n_chk++; if (o_err !== 1'b1) $display("FAIL t3_err_pulse got %0b want 1", o_err); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL t3_busy got %0b want 0", o_busy); else n_pass++;
        tick();
        n_chk++; if (o_err !== 1'b0) $display("FAIL t3_err_width got %0b want 0", o_err); else n_pass++;
        send_spike($urandom_range(101, 127));
        n_chk++; if (o_err !== 1'b1) $display("FAIL t3_err_pulse2 got %0b want 1", o_err); else n_pass++;
        repeat (6) tick();
        n_chk++; if (o_rd_addr !== a0) $display("FAIL t3_addr got %0d want %0d", o_rd_addr, a0); else n_pass++;
        n_chk++; if (addr_q.size() != 0) $display("FAIL t3_reads got %0d want 0", addr_q.size()); else n_pass++;
        n_chk++; if (o_busy !== 1'b0 || o_err !== 1'b0) $display("FAIL t3_quiet got busy=%0b err=%0b want 0 0", o_busy, o_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int acc = 0;
        int issued_at_2nd = -1;
        logic was;
        mode = 2;
        i_spk_valid = 1'b1;
        i_spk_idx = 7'd5;
        while (acc < 2 && n < 3000) begin
            was = o_spk_ready;
            tick();
            n++;
            if (was) begin
                acc++;
                if (acc == 1) begin
                    i_spk_idx = 7'd6;
                    n_chk++;
                    if (o_spk_ready !== 1'b0) $display("FAIL t4_ready_drop got %0b want 0", o_spk_ready); else n_pass++;
                end else
                    issued_at_2nd = addr_q.size();
            end
        end
        i_spk_valid = 1'b0;
        n_chk++; if (acc != 2) $display("FAIL t4_accepts got %0d want 2", acc); else n_pass++;
        n_chk++; if (issued_at_2nd != 100) $display("FAIL t4_second_accept_issued got %0d want 100", issued_at_2nd); else n_pass++;
        wait_idle();
        build(5, 2);
        n_chk++;
        if (addr_q.size() != 200) $display("FAIL t4_addr_count got %0d want 200", addr_q.size()); else n_pass++;
        for (int k = 0; k < addr_q.size() && k < 200; k++) begin
            n_chk++;
            if (addr_q[k] !== 14'(500 + k)) $display("FAIL t4_addr[%0d] got %0d want %0d", k, addr_q[k], 500 + k);
            else n_pass++;
        end
        n_chk++;
        if (out_q.size() != exp_q.size()) $display("FAIL t4_entry_count got %0d want %0d", out_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            n_chk++;
            if (out_q[k] !== exp_q[k]) $display("FAIL t4_entry[%0d] got %h want %h", k, out_q[k], exp_q[k]);
            else n_pass++;
        end
        addr_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset_mid_row();
        int n = 0;
        mode = 0;
        send_spike(7);
        while (addr_q.size() < 41 && n < 500) begin
            tick();
            n++;
        end
        n_chk++; if (addr_q.size() < 41) $display("FAIL t5_reach_post40 got %0d want 41", addr_q.size()); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_chk++; if (o_syn_valid !== 1'b0) $display("FAIL t5_valid got %0b want 0", o_syn_valid); else n_pass++;
        n_chk++; if ({o_syn_post_idx, o_syn_weight, o_syn_last} !== 16'd0) $display("FAIL t5_payload got %h want 0", {o_syn_post_idx, o_syn_weight, o_syn_last}); else n_pass++;
        n_chk++; if (o_rd_addr !== 14'd0) $display("FAIL t5_addr got %0d want 0", o_rd_addr); else n_pass++;
        n_chk++; if (o_busy !== 1'b0 || o_spk_ready !== 1'b0 || o_err !== 1'b0) $display("FAIL t5_ctrl got busy=%0b ready=%0b err=%0b want 0 0 0", o_busy, o_spk_ready, o_err); else n_pass++;
        tick();
        rst_n = 1'b1;
        addr_q.delete();
        out_q.delete();
        outstanding = 0;
        repeat (12) tick();
        n_chk++; if (out_q.size() != 0) $display("FAIL t5_ghost_entries got %0d want 0", out_q.size()); else n_pass++;
        n_chk++; if (addr_q.size() != 0) $display("FAIL t5_ghost_reads got %0d want 0", addr_q.size()); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL t5_busy got %0b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(1, 99);
            repeat ($urandom_range(0, 3)) tick();
            test_row($sformatf("rnd%0d_row%0d", i, r), r, 2);
        end
    endtask

`ifdef ZERO_SKIP_EN
    task automatic test_zero_skip();
        logic seen;
        zero_mode = 1'b1;
        zrow = 8;
        test_row("t6_row8", 8, 2);
        build(8, 1);
        n_chk++; if (exp_q.size() != 98) $display("FAIL t6_model_count got %0d want 98", exp_q.size()); else n_pass++;
        seen = 1'b0;
        foreach (exp_q[k])
            if (exp_q[k][15:9] == 7'd0 || exp_q[k][15:9] == 7'd10)
                seen = 1'b1;
        n_chk++; if (seen !== 1'b0) $display("FAIL t6_zero_present got %0b want 0", seen); else n_pass++;
        n_chk++; if (exp_q[exp_q.size()-1] !== {7'd99, 8'd0, 1'b1}) $display("FAIL t6_last got %h want %h", exp_q[exp_q.size()-1], {7'd99, 8'd0, 1'b1}); else n_pass++;
        zero_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_mid_row();
        test_random();
`ifdef ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
